// File: rtl/gcd_dest_pkg.sv
// -----------------------------------------------------------------------------
// gcd_dest_pkg
// Shared definitions for the GCD equivalence miter:
//   GCD_W          : operand / result width (6 bits)
//   gcd_word_t     : one operand-sized word
//   dest_sel_e     : one-hot destination select used by the dest engine
//   engine_state_t : the observable register set of one engine, as seen
//                    by the miter compare
// -----------------------------------------------------------------------------
package gcd_dest_pkg;

  localparam int GCD_W = 6;

  typedef logic [GCD_W-1:0] gcd_word_t;

  // One-hot so each bit can directly steer one write path.
  typedef enum logic [1:0] {
    SEL_SWAP = 2'b01,  // a <- b, b <- a
    SEL_SUB  = 2'b10   // a <- a - b, b holds
  } dest_sel_e;

  typedef struct packed {
    logic      busy;
    logic      done;
    gcd_word_t res;
    gcd_word_t a;
    gcd_word_t b;
  } engine_state_t;

endpackage : gcd_dest_pkg

// File: rtl/gcd_dest_miter_if.sv
// -----------------------------------------------------------------------------
// gcd_dest_miter_if
// Command/observation bundle of the GCD miter.
//   start : load a_in/b_in into the engines this cycle
//   a_in  : operand A
//   b_in  : operand B
//   equiv : engines' observable state agrees
// Modports:
//   master : stimulus side (drives the command, observes equiv)
//   slave  : miter side (consumes the command, reports equiv)
//   engine : one GCD engine (command inputs only)
// -----------------------------------------------------------------------------
interface gcd_dest_miter_if;
  import gcd_dest_pkg::*;

  logic      start;
  gcd_word_t a_in;
  gcd_word_t b_in;
  logic      equiv;

  modport master (output start, output a_in, output b_in, input  equiv);
  modport slave  (input  start, input  a_in, input  b_in, output equiv);
  modport engine (input  start, input  a_in, input  b_in);

endinterface : gcd_dest_miter_if

// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
// Cycle-accurate subtractive-Euclid GCD engine, 6-bit operands.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   cmd   : start / a_in / b_in command (engine modport)
//   state : registered observable state {busy, done, res, a, b}
// Parameter:
//   DEST_STYLE = 0 : reference datapath - separate comparator and subtractor,
//                    swap through explicit muxes.
//   DEST_STYLE = 1 : dest datapath - a single 7-bit subtractor whose borrow is
//                    the compare, a one-hot destination select and a single
//                    write port onto a; b only changes on a swap.
// Behaviour (both styles):
//   start          : a<-a_in, b<-b_in, busy<-1, done<-0 (res holds); aborts
//                    any run in progress.
//   busy, b==0     : res<-a, done<-1, busy<-0
//   busy, a<b      : swap a and b
//   busy, a>=b     : a<-a-b
//   idle           : everything holds
// -----------------------------------------------------------------------------
module gcd_engine
  import gcd_dest_pkg::*;
#(
  parameter bit DEST_STYLE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  gcd_dest_miter_if.engine        cmd,
  output engine_state_t           state
);

  gcd_word_t a_q,    a_d;
  gcd_word_t b_q,    b_d;
  gcd_word_t res_q,  res_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;

  // Next a/b for one Euclid step (only used when busy and b != 0).
  gcd_word_t step_a;
  gcd_word_t step_b;

  generate
    if (DEST_STYLE == 1'b0) begin : g_ref
      logic      a_lt_b;
      gcd_word_t diff;

      always_comb begin
        a_lt_b = (a_q < b_q);
        diff   = a_q - b_q;
        step_a = a_lt_b ? b_q : diff;
        step_b = a_lt_b ? a_q : b_q;
      end
    end else begin : g_dst
      logic [GCD_W:0] sub_w;
      dest_sel_e      sel;
      gcd_word_t      a_wr_data;

      always_comb begin
        // The extra top bit of the 7-bit difference is the borrow, i.e. a < b.
        sub_w     = {1'b0, a_q} - {1'b0, b_q};
        sel       = sub_w[GCD_W] ? SEL_SWAP : SEL_SUB;
        a_wr_data = sub_w[GCD_W-1:0];
        step_b    = b_q;
        case (sel)
          SEL_SWAP: begin
            a_wr_data = b_q;
            step_b    = a_q;
          end
          SEL_SUB:  a_wr_data = sub_w[GCD_W-1:0];
          default:  a_wr_data = sub_w[GCD_W-1:0];
        endcase
        // Single write port onto a: whatever the select picked.
        step_a = a_wr_data;
      end
    end
  endgenerate

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    busy_d = busy_q;
    done_d = done_q;

    if (cmd.start) begin
      a_d    = cmd.a_in;
      b_d    = cmd.b_in;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      if (b_q == '0) begin
        res_d  = a_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        a_d = step_a;
        b_d = step_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign state = '{busy: busy_q, done: done_q, res: res_q, a: a_q, b: b_q};

endmodule : gcd_engine

// File: rtl/gcd_dest_miter.sv
// -----------------------------------------------------------------------------
// gcd_dest_miter
// Equivalence miter between the reference GCD engine (u_ref) and the
// single-subtractor destination-select engine (u_dst). Both engines see the
// same command every cycle; equiv reports whether their observable state
// agrees.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : load Ain/Bin into both engines
//   Ain   : operand A (6 bits)
//   Bin   : operand B (6 bits)
//   equiv : 1 when busy/done/res agree and, while busy, a/b agree too.
//           Purely a function of registered state.
// Configuration:
//   GCD_DEST_STICKY_EN defined : a mismatch_q flag latches the first failing
//     compare and holds equiv low until reset.
//   GCD_DEST_STICKY_EN undefined : equiv is the per-cycle compare and recovers
//     once the engines agree again.
// -----------------------------------------------------------------------------
module gcd_dest_miter
  import gcd_dest_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  gcd_word_t Ain,
  input  gcd_word_t Bin,
  output logic      equiv
);

  gcd_dest_miter_if cmd_if ();

  assign cmd_if.start = start;
  assign cmd_if.a_in  = Ain;
  assign cmd_if.b_in  = Bin;

  engine_state_t st_ref;
  engine_state_t st_dst;

  gcd_engine #(.DEST_STYLE(1'b0)) u_ref (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .state (st_ref)
  );

  gcd_engine #(.DEST_STYLE(1'b1)) u_dst (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .state (st_dst)
  );

  // a/b are scratch once a run has finished, so they only count while busy.
  logic state_match;

  always_comb begin
    state_match = (st_ref.busy == st_dst.busy) &&
                  (st_ref.done == st_dst.done) &&
                  (st_ref.res  == st_dst.res)  &&
                  (!st_ref.busy || ((st_ref.a == st_dst.a) && (st_ref.b == st_dst.b)));
  end

  logic equiv_w;

`ifdef GCD_DEST_STICKY_EN
  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q | ~state_match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  // The live compare is included so equiv drops in the very cycle of the
  // first disagreement, before mismatch_q has had an edge to capture it.
  assign equiv_w = ~mismatch_q & state_match;
`else
  assign equiv_w = state_match;
`endif

  assign cmd_if.equiv = equiv_w;
  assign equiv        = cmd_if.equiv;

endmodule : gcd_dest_miter

// File: tb/tb_gcd_dest_miter.sv
// -----------------------------------------------------------------------------
// tb_gcd_dest_miter
// Self-checking bench for gcd_dest_miter. Expected results come from a
// behavioural model: GCD via the remainder form of Euclid, and latency from
// counting subtract/swap steps on plain integers.
// -----------------------------------------------------------------------------
module tb_gcd_dest_miter;
  import gcd_dest_pkg::*;

  logic clk = 1'b0;
  logic reset;

  gcd_dest_miter_if bus ();

  gcd_dest_miter dut (
    .clk   (clk),
    .reset (reset),
    .start (bus.start),
    .Ain   (bus.a_in),
    .Bin   (bus.b_in),
    .equiv (bus.equiv)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- model
  function automatic int model_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Cycles from the load edge until done is visible: one per step plus one
  // completion cycle.
  function automatic int model_latency(input int x, input int y);
    int n = 0;
    int t;
    while (y != 0) begin
      if (x < y) begin
        t = x; x = y; y = t;
      end else begin
        x = x - y;
      end
      n++;
    end
    return n + 1;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic issue_start(input int x, input int y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 6'(x);
    bus.b_in  = 6'(y);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    // Operand changes after the load edge must not matter.
    bus.a_in  = 6'($urandom);
    bus.b_in  = 6'($urandom);
  endtask

  task automatic run_case(input int x, input int y, input string tag);
    int exp_res;
    int exp_lat;
    int n;
    bit eq_bad;
    exp_res = model_gcd(x, y);
    exp_lat = model_latency(x, y);
    issue_start(x, y);
    eq_bad = (bus.equiv !== 1'b1);

    checks++;
    if (dut.u_ref.done_q !== 1'b0 || dut.u_ref.busy_q !== 1'b1) begin
      errors++;
      $display("FAIL %s load: done=%b busy=%b expected done=0 busy=1", tag,
               dut.u_ref.done_q, dut.u_ref.busy_q);
    end

    n = 0;
    while (dut.u_ref.done_q !== 1'b1 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.equiv !== 1'b1) eq_bad = 1'b1;
    end

    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_lat);
    end
    checks++;
    if (dut.u_ref.res_q !== 6'(exp_res)) begin
      errors++;
      $display("FAIL %s res_ref: got %0d expected %0d", tag, dut.u_ref.res_q, exp_res);
    end
    checks++;
    if (dut.u_dst.res_q !== 6'(exp_res) || dut.u_dst.done_q !== 1'b1) begin
      errors++;
      $display("FAIL %s res_dst: got %0d done=%b expected %0d done=1", tag,
               dut.u_dst.res_q, dut.u_dst.done_q, exp_res);
    end
    checks++;
    if (eq_bad) begin
      errors++;
      $display("FAIL %s equiv: dropped to 0 during run, expected 1 throughout", tag);
    end

    // Idle: done and res hold.
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.u_ref.done_q !== 1'b1 || dut.u_dst.res_q !== 6'(exp_res) ||
        bus.equiv !== 1'b1) begin
      errors++;
      $display("FAIL %s hold: done=%b res=%0d equiv=%b expected done=1 res=%0d equiv=1",
               tag, dut.u_ref.done_q, dut.u_dst.res_q, bus.equiv, exp_res);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.equiv !== 1'b1) begin
      errors++;
      $display("FAIL reset equiv: got %b expected 1", bus.equiv);
    end
    checks++;
    if (dut.u_ref.done_q !== 1'b0 || dut.u_dst.done_q !== 1'b0) begin
      errors++;
      $display("FAIL reset done: ref=%b dst=%b expected 0", dut.u_ref.done_q, dut.u_dst.done_q);
    end
    checks++;
    if (dut.u_ref.res_q !== 6'd0 || dut.u_dst.res_q !== 6'd0) begin
      errors++;
      $display("FAIL reset res: ref=%0d dst=%0d expected 0", dut.u_ref.res_q, dut.u_dst.res_q);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_case(2, 4, "gcd_2_4");
    run_case(5, 0, "gcd_5_0");
    run_case(0, 0, "gcd_0_0");
    run_case(0, 7, "gcd_0_7");
    run_case(63, 1, "gcd_63_1");
  endtask

  task automatic test_restart();
    issue_start(63, 1);
    repeat (10) @(posedge clk);
    run_case(12, 18, "restart_12_18");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_case(int'($urandom_range(63, 0)), int'($urandom_range(63, 0)), "random");
    end
  endtask

  task automatic test_fault();
    bit eq_bad;
    bit eq_good;
    int n;
    issue_start(12, 18);
    // Engine holds a=12 here; corrupt the dest copy for this cycle only.
    force dut.u_dst.a_q = 6'd63;
    #1;
    checks++;
    if (bus.equiv !== 1'b0) begin
      errors++;
      $display("FAIL fault_detect equiv: got %b expected 0", bus.equiv);
    end
    // Reload both engines so they resynchronise at the next edge.
    bus.start = 1'b1;
    bus.a_in  = 6'd9;
    bus.b_in  = 6'd6;
    #1;
    release dut.u_dst.a_q;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    eq_bad  = (bus.equiv !== 1'b1);
    eq_good = (bus.equiv === 1'b1);
    n = 0;
    while (dut.u_dst.done_q !== 1'b1 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.equiv !== 1'b1) eq_bad = 1'b1;
      if (bus.equiv === 1'b1) eq_good = 1'b1;
    end
    checks++;
    if (dut.u_dst.res_q !== 6'd3) begin
      errors++;
      $display("FAIL fault_rerun res: got %0d expected 3", dut.u_dst.res_q);
    end
`ifdef GCD_DEST_STICKY_EN
    checks++;
    if (eq_good) begin
      errors++;
      $display("FAIL fault_sticky equiv: got 1 after mismatch, expected 0 until reset");
    end
`else
    checks++;
    if (eq_bad) begin
      errors++;
      $display("FAIL fault_recover equiv: got 0 after resync, expected 1");
    end
`endif
  endtask

  task automatic test_reset_midrun();
    issue_start(63, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.equiv !== 1'b1) begin
      errors++;
      $display("FAIL midreset equiv: got %b expected 1", bus.equiv);
    end
    checks++;
    if (dut.u_ref.busy_q !== 1'b0 || dut.u_dst.busy_q !== 1'b0 ||
        dut.u_ref.a_q !== 6'd0 || dut.u_dst.a_q !== 6'd0 ||
        dut.u_ref.b_q !== 6'd0 || dut.u_dst.b_q !== 6'd0) begin
      errors++;
      $display("FAIL midreset state: busy=%b/%b a=%0d/%0d b=%0d/%0d expected all 0",
               dut.u_ref.busy_q, dut.u_dst.busy_q, dut.u_ref.a_q, dut.u_dst.a_q,
               dut.u_ref.b_q, dut.u_dst.b_q);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_case(9, 6, "after_reset_9_6");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_random();
    test_fault();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gcd_dest_miter
